// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core constants, register indices and word types
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd1;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

    typedef logic [XLEN-1:0]   xword_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file read/write/debug port bundle
interface register_file_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            reg_write;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dbg_addr,
        input  rs1_data, rs2_data, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dbg_addr,
        output rs1_data, rs2_data, dbg_data
    );
endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: x0 mask, optional write forwarding, reset force-0
module regfile_read_port
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 0
) (
    input  logic            rst,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] stored,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data
);
    always_comb begin
        data = stored;
        if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            data = wr_data;
        end
        // x0 masking last so a forwarded write to x0 can never leak through
        if (rst || addr == AW'(REG_ZERO)) begin
            data = '0;
        end
    end
endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file, two read ports, one write port, debug read
module register_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   rf
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.reg_write && rf.rd_addr != '0) begin
            regs[rf.rd_addr] <= rf.rd_data;
        end
    end

    regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs1 (
        .rst     (rst),
        .addr    (rf.rs1_addr),
        .stored  (regs[rf.rs1_addr]),
        .wr_en   (rf.reg_write),
        .wr_addr (rf.rd_addr),
        .wr_data (rf.rd_data),
        .data    (rf.rs1_data)
    );

    regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs2 (
        .rst     (rst),
        .addr    (rf.rs2_addr),
        .stored  (regs[rf.rs2_addr]),
        .wr_en   (rf.reg_write),
        .wr_addr (rf.rd_addr),
        .wr_data (rf.rd_data),
        .data    (rf.rs2_data)
    );

    // debug view always shows committed state, so forwarding is tied off
    regfile_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) u_dbg (
        .rst     (rst),
        .addr    (rf.dbg_addr),
        .stored  (regs[rf.dbg_addr]),
        .wr_en   (1'b0),
        .wr_addr ('0),
        .wr_data ('0),
        .data    (rf.dbg_data)
    );
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file with BYPASS=0 and BYPASS=1
module tb_register_file;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] r1_0, r2_0, dbg_0, r1_1, r2_1, dbg_1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_a, rs2_a, rd_a, dbg_a;
    logic [31:0] rd_d;
    logic        we;

    logic [31:0] ref_regs [32];
    exp_t        sb_q [$];
    int          total = 0;
    int          bad   = 0;

    register_file_if #(.XLEN(32), .AW(5)) if0 ();
    register_file_if #(.XLEN(32), .AW(5)) if1 ();

    assign if0.rs1_addr  = rs1_a;
    assign if0.rs2_addr  = rs2_a;
    assign if0.reg_write = we;
    assign if0.rd_addr   = rd_a;
    assign if0.rd_data   = rd_d;
    assign if0.dbg_addr  = dbg_a;
    assign if1.rs1_addr  = rs1_a;
    assign if1.rs2_addr  = rs2_a;
    assign if1.reg_write = we;
    assign if1.rd_addr   = rd_a;
    assign if1.rd_data   = rd_d;
    assign if1.dbg_addr  = dbg_a;

    register_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .rf  (if0.slave)
    );

    register_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .rf  (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 32'h0;
        if (byp && we && rd_a == a) return rd_d;
        return ref_regs[a];
    endfunction

    task automatic step();
        exp_t e;
        exp_t g;
        e.r1_0  = model_read(rs1_a, 1'b0);
        e.r2_0  = model_read(rs2_a, 1'b0);
        e.dbg_0 = model_read(dbg_a, 1'b0);
        e.r1_1  = model_read(rs1_a, 1'b1);
        e.r2_1  = model_read(rs2_a, 1'b1);
        e.dbg_1 = model_read(dbg_a, 1'b0);
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        check("b0_rs1", if0.rs1_data, g.r1_0);
        check("b0_rs2", if0.rs2_data, g.r2_0);
        check("b0_dbg", if0.dbg_data, g.dbg_0);
        check("b1_rs1", if1.rs1_data, g.r1_1);
        check("b1_rs2", if1.rs2_data, g.r2_1);
        check("b1_dbg", if1.dbg_data, g.dbg_1);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        end else if (we && rd_a != 5'd0) begin
            ref_regs[rd_a] = rd_d;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; rd_a = a; rd_d = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        rst = 1'b1; we = 1'b0; rs1_a = '0; rs2_a = '0; rd_a = '0; dbg_a = '0; rd_d = '0;
        step();
        step();
        rst = 1'b0;

        // reset clears a preloaded register, then sweep all via dbg
        wr(5'd5, 32'hDEADBEEF); rs1_a = 5'd5; dbg_a = 5'd5;
        step();
        we = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            dbg_a = 5'(i); rs1_a = 5'(i); rs2_a = 5'(31 - i);
            step();
        end

        // basic write/read, both ports on same register
        wr(5'd7, 32'h12345678); rs1_a = 5'd7; rs2_a = 5'd7; dbg_a = 5'd7;
        step();
        wr(REG_SP, 32'h0000_8000); rs1_a = REG_SP; rs2_a = 5'd7;
        step();
        we = 1'b0; rs1_a = 5'd7; dbg_a = REG_SP;
        step();

        // x0 writes ignored, including same-cycle forwarding
        wr(REG_ZERO, 32'hFFFFFFFF); rs1_a = 5'd0; rs2_a = 5'd0; dbg_a = 5'd0;
        step();
        we = 1'b0;
        step();

        // same-cycle hazard on x9
        wr(5'd9, 32'h1); rs1_a = REG_RA; rs2_a = 5'd9;
        step();
        wr(5'd9, 32'h2); rs1_a = 5'd9; rs2_a = 5'd9; dbg_a = 5'd9;
        step();
        we = 1'b0;
        step();

        // reset wins over a simultaneous write
        wr(5'd3, 32'h55); rs1_a = 5'd3;
        step();
        wr(5'd3, 32'hAA); rst = 1'b1;
        step();
        rst = 1'b0; we = 1'b0; dbg_a = 5'd3;
        step();

        // random traffic
        for (int n = 0; n < 1000; n++) begin
            rst   = ($urandom_range(0, 63) == 0);
            we    = $urandom_range(0, 1) == 1;
            rd_a  = 5'($urandom_range(0, 31));
            rd_d  = $urandom;
            rs1_a = ($urandom_range(0, 3) == 0) ? rd_a : 5'($urandom_range(0, 31));
            rs2_a = ($urandom_range(0, 3) == 0) ? rd_a : 5'($urandom_range(0, 31));
            dbg_a = 5'($urandom_range(0, 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
